// File: rtl/ram_xy_pkg.sv
// ram_xy_pkg: shared widths and types for the 16x4 X/Y-select register-file RAM
package ram_xy_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int SEL_W  = 2;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;
endpackage

// File: rtl/ram_xy_dec.sv
// ram_xy_dec: 2-to-4 one-hot line decoder used for the row and column selects
module ram_xy_dec
  import ram_xy_pkg::*;
(
  input  sel_t       sel,
  output logic [3:0] hot
);
  // exactly one line is active for every select value
  always_comb hot = 4'b0001 << sel;
endmodule

// File: rtl/ram_xy_16x4.sv
// ram_xy_16x4: 16x4 RAM, linear write address, coincident X/Y read select, registered Do
// Optional macro RAM_WRITE_THROUGH_EN: write-first bypass on a read/write address collision
module ram_xy_16x4
  import ram_xy_pkg::*;
#(
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  WE,
  input  addr_t A,
  input  logic  W,
  input  logic  X,
  input  logic  Y,
  input  logic  Z,
  input  sel_t  Xi,
  input  sel_t  Yi,
  output data_t Do
);
  data_t            din;
  data_t            mem [DEPTH];
  logic [DEPTH-1:0] wsel;
  logic [3:0]       row;
  logic [3:0]       col;
  data_t            rd;
  data_t            nxt;
  assign din  = {Z, Y, X, W};
  assign wsel = DEPTH'(1) << A;
  ram_xy_dec u_row (.sel(Yi), .hot(row));
  ram_xy_dec u_col (.sel(Xi), .hot(col));
  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    data_t word;
    if (CLR_ON_RESET) begin : g_clr
      // word storage, cleared by reset; each word only reacts to its own decode line
      always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) word <= '0;
        else if (WE && wsel[k]) word <= din;
    end else begin : g_hold
      // word storage that survives reset; writes are still blocked while reset is low
      always_ff @(posedge CLK)
        if (RST_N && WE && wsel[k]) word <= din;
    end
    assign mem[k] = word;
  end
  // AND-OR read mux: word k contributes when its row and column lines are both active
  always_comb begin
    rd = '0;
    for (int k = 0; k < DEPTH; k++)
      rd |= {DATA_W{row[k/4] & col[k%4]}} & mem[k];
  end
`ifdef RAM_WRITE_THROUGH_EN
  // write-first: a collision forwards the incoming data straight to Do
  always_comb nxt = (WE && A == {Yi, Xi}) ? din : rd;
`else
  // read-first: a collision returns the word's old contents
  always_comb nxt = rd;
`endif
  // registered read port
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) Do <= '0;
    else Do <= nxt;
endmodule

// File: tb/tb_ram_xy_16x4.sv
// tb_ram_xy_16x4: table, directed and random checks of ram_xy_16x4 against an array model
module tb_ram_xy_16x4;
`ifdef RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif
  logic       CLK = 0, RST_N = 1, WE = 0, W = 0, X = 0, Y = 0, Z = 0;
  logic [3:0] A = 0, do1, do0;
  logic [1:0] Xi = 0, Yi = 0;
  logic [3:0] mdl1 [16];
  logic [3:0] mdl0 [16];
  bit         known0 [16];
  int         checks = 0, failures = 0;

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [3:0] d;
    logic [1:0] yi;
    logic [1:0] xi;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [9];

  ram_xy_16x4 dut (.CLK(CLK), .RST_N(RST_N), .WE(WE), .A(A), .W(W), .X(X), .Y(Y), .Z(Z),
                   .Xi(Xi), .Yi(Yi), .Do(do1));
  ram_xy_16x4 #(.CLR_ON_RESET(1'b0)) dut0 (.CLK(CLK), .RST_N(RST_N), .WE(WE), .A(A), .W(W),
                   .X(X), .Y(Y), .Z(Z), .Xi(Xi), .Yi(Yi), .Do(do0));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] a, input logic [3:0] d,
                       input logic [1:0] yi, input logic [1:0] xi);
    WE = we; A = a; {Z, Y, X, W} = d; Yi = yi; Xi = xi;
  endtask

  task automatic step(input string nm);
    logic [3:0] ra, din, e1, e0;
    bit         byp, k0;
    ra  = {Yi, Xi};
    din = {Z, Y, X, W};
    byp = WE && A == ra && WT;
    if (RST_N) begin
      e1 = byp ? din : mdl1[ra];
      e0 = byp ? din : mdl0[ra];
      k0 = byp || known0[ra];
      if (WE) begin
        mdl1[A] = din;
        mdl0[A] = din;
        known0[A] = 1;
      end
    end else begin
      e1 = 0; e0 = 0; k0 = 1;
    end
    @(posedge CLK); #1;
    chk({nm, "_do"}, do1, e1);
    if (k0) chk({nm, "_do0"}, do0, e0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mdl1[i] = 0; mdl0[i] = 0; known0[i] = 0; end
    tbl[0] = '{1, 5, 4'hA, 0, 0, 4'h0};
    tbl[1] = '{0, 0, 4'h0, 1, 1, 4'hA};
    tbl[2] = '{1, 3, 4'h6, 1, 1, 4'hA};
    tbl[3] = '{0, 0, 4'h0, 0, 3, 4'h6};
    tbl[4] = '{1, 15, 4'hF, 0, 3, 4'h6};
    tbl[5] = '{0, 0, 4'h0, 3, 3, 4'hF};
    tbl[6] = '{0, 5, 4'h0, 1, 1, 4'hA};
    tbl[7] = '{1, 0, 4'h9, 3, 3, 4'hF};
    tbl[8] = '{0, 0, 4'h0, 0, 0, 4'h9};
    #1 RST_N = 0;
    #1 chk("reset_do", do1, 4'h0);
    chk("reset_do0", do0, 4'h0);
    drive(1, 4, 4'h7, 0, 0);
    step("in_reset");
    RST_N = 1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 2'(i >> 2), 2'(i));
      step("clear_sweep");
    end
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].yi, tbl[i].xi);
      step("table");
      chk($sformatf("table%0d", i), do1, tbl[i].exp);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), ~4'(i), 0, 0);
      step("sweep_wr");
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 2'(i >> 2), 2'(i));
      step("sweep_rd");
    end
    drive(0, 0, 0, 3, 3); step("row_major");
    chk("word15", do1, 4'h0);
    drive(0, 0, 0, 0, 3); step("row_major");
    chk("word3", do1, 4'hC);
    drive(0, 7, 4'hF, 0, 0); step("we_low");
    drive(0, 0, 0, 1, 3); step("we_low_rd");
    chk("we_low_mem7", do1, 4'h8);
    drive(1, 9, 4'h3, 0, 0); step("coll_pre");
    drive(1, 9, 4'hC, 2, 1); step("coll");
    chk("collision", do1, WT ? 4'hC : 4'h3);
    drive(0, 0, 0, 2, 1); step("coll_next");
    chk("collision_next", do1, 4'hC);
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
      step("rand");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i), 4'(i) ^ 4'h5, 2'($urandom), 2'($urandom));
      step("rst_sweep");
      if (i == 4) begin
        #2 RST_N = 0;
        for (int k = 0; k < 16; k++) mdl1[k] = 0;
        #1 chk("async_do", do1, 4'h0);
        chk("async_do0", do0, 4'h0);
        drive(1, 2, 4'hB, 0, 2);
        step("rst_hold");
        step("rst_hold");
        RST_N = 1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 2'(i >> 2), 2'(i));
      step("post_rst_rd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_xy_16x4.md
Name: ram_xy_16x4

Overview:
- 16-word x 4-bit simple dual-port register-file RAM.
- Write port: linear 4-bit address A; data assembled from four scalar bit inputs W, X, Y, Z.
- Read port: coincident X/Y selection, with column index Xi and row index Yi, each 2 bits.
- Used as a small lookup/scratch store in the lab datapath; single clock domain.

Parameters:
- CLR_ON_RESET, default 1, meaning: 1 = asynchronous reset clears all 16 words to 4'h0; 0 = reset clears only Do and the memory array holds its contents.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- WE  in  1  write enable, active high, sampled on the CLK rising edge.
- A  in  4  write address, word 0..15.
- W  in  1  write data bit 0 (LSB).
- X  in  1  write data bit 1.
- Y  in  1  write data bit 2.
- Z  in  1  write data bit 3 (MSB).
- Xi  in  2  read column select.
- Yi  in  2  read row select.
- Do  out  4  registered read data.

Behaviour:
- Write data: Din = {Z,Y,X,W}.
- Read address: Ra = {Yi,Xi}, giving row-major word index Yi*4+Xi.
- Internally, Yi and Xi are each one-hot decoded (2-to-4). Word k is selected when row line k[3:2] AND column line k[1:0] are both active. Exactly one word is selected at any time.
- Reset (RST_N low, asynchronous):
  - Do = 4'h0 immediately.
  - If CLR_ON_RESET=1, mem[0..15] = 4'h0.
  - Writes are ignored while RST_N is low.
  - Release of reset is synchronised by the usual two-flop deassertion at system level; no local synchroniser is built in.
- Write: on a rising CLK edge with RST_N high and WE=1, mem[A] <= Din. With WE=0 the memory is unchanged.
- Read: on every rising CLK edge with RST_N high, Do <= mem[Ra]. Latency is 1 cycle from Xi/Yi sampled to Do valid. Do holds its value between edges.
- Collision (WE=1 and A==Ra on the same edge): default is read-first. Do gets the old mem[Ra]; the new data is visible on the next edge.
- A, Xi and Yi are all full-range, so there are no out-of-range addresses and no wrap logic.
- X or Z on any input:
  - No assertion is required.
  - X on WE or A must not corrupt words other than the addressed word in synthesis.
- Reset asserted mid-write: the reset wins; if CLR_ON_RESET=1 the word being written ends at 0.

Optional Feature:
- Macro RAM_WRITE_THROUGH_EN.
- Defined: on a collision (WE=1, A==Ra), Do <= Din on that same edge (write-first bypass). All other behaviour is unchanged.
- Undefined: read-first collision behaviour as in Behaviour.

Decomposition:
- Package ram_xy_pkg holds:
  - localparams ADDR_W=4, DATA_W=4, DEPTH=16, SEL_W=2.
  - typedefs addr_t (logic [3:0]), data_t (logic [3:0]), sel_t (logic [1:0]).
- One sub-module: ram_xy_dec, a 2-to-4 one-hot decoder, instantiated twice (row from Yi, column from Xi).
- The top level holds the array, the write decode from A, the AND-OR read mux, the Do register, and the bypass.

Test Plan:
- Reset: RST_N=0 with CLR_ON_RESET=1 -> Do=0 immediately. Then, reset released and no writes, sweep {Yi,Xi}=0..15 -> Do=0 for every word.
- Write/readback: write A=5 with {Z,Y,X,W}=1010, WE=1; then WE=0, Yi=1, Xi=1 -> Do=4'hA one cycle after the edge.
- Full sweep: write mem[i]=~i for i=0..15; read all 16 via Yi/Xi -> Do=~i. Yi=3, Xi=3 addresses word 15 and Yi=0, Xi=3 addresses word 3, confirming row-major order.
- WE low: WE=0 with A=7 and Din=1111 -> mem[7] is unchanged (previous value read back).
- Collision: mem[9]=3; WE=1, A=9, Din=C, Yi=2, Xi=1 on the same edge -> Do=3 without RAM_WRITE_THROUGH_EN, Do=C with it; Do=C on the next edge in both cases.
- Async reset mid-run: RST_N pulsed low between clock edges during a write sweep -> Do=0 without waiting for a clock edge. Memory reads back all zero with CLR_ON_RESET=1 and keeps prior contents with CLR_ON_RESET=0.
